// File: rtl/vga_timing_pkg.sv
// Shared types and default timing constants for the VGA raster sequencer.
// Holds the per-axis phase encoding and the axis-total helper.
// No logic; imported by the axis counter and the top level.
package vga_timing_pkg;

    // Phase of one raster axis; both axes walk through these in order.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Length of one full axis period in counts.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480 @ 72 Hz on a 31.5 MHz pixel clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 128;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 28;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM (ACTIVE/FRONT/SYNC/BACK).
// Count and phase register on the step edge; phase_o/wrap_o describe the coming edge.
// step=0 holds all state; clear has priority over step and returns to count 0 / ACTIVE.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         step_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic [1:0]   phase_o,   // phase of the count being loaded on this edge
    output logic         wrap_o     // this step takes the count from TOTAL-1 back to 0
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] END_FRONT  = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

    phase_e       phase_q, phase_d;
    logic [W-1:0] count_q, count_d;
    logic         at_last;

    assign at_last = (count_q == LAST);

    // State register: count and phase move together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_ACTIVE;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    // Next state: phase changes on the last count of the current phase.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        if (clear_i) begin
            phase_d = PH_ACTIVE;
            count_d = '0;
        end else if (step_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
            case (phase_q)
                PH_ACTIVE: if (count_q == END_ACTIVE) phase_d = PH_FRONT;
                PH_FRONT:  if (count_q == END_FRONT)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == END_SYNC)   phase_d = PH_BACK;
                PH_BACK:   if (at_last)               phase_d = PH_ACTIVE;
                default:                              phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Outputs: next phase lets the top register decodes aligned with the count.
    always_comb begin
        count_o = count_q;
        phase_o = phase_d;
        wrap_o  = step_i && !clear_i && at_last;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: h/v counters, sync, blank, line/frame strobes, delayed sync/blank.
// sync/blank are registered from next-count decode, so they align with hcount/vcount; *_d lag PIPE_DELAY.
// enable=0 freezes everything (delay line included); restart overrides the freeze.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync_d,
    output logic        vsync_d,
    output logic        blank_b_d
);

    logic       h_wrap, v_wrap;
    logic [1:0] h_phase_nxt, v_phase_nxt;
    logic       hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;
    logic       hsync_d_n, vsync_d_n, blank_d_n, line_start_d, frame_start_d;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
    ) u_h (
        .clk_i   (pixel_clock),
        .rst_i   (reset),
        .step_i  (enable),
        .clear_i (restart),
        .count_o (hcount),
        .phase_o (h_phase_nxt),
        .wrap_o  (h_wrap)
    );

    // Vertical axis advances one line each time the horizontal axis wraps.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
    ) u_v (
        .clk_i   (pixel_clock),
        .rst_i   (reset),
        .step_i  (h_wrap),
        .clear_i (restart),
        .count_o (vcount),
        .phase_o (v_phase_nxt),
        .wrap_o  (v_wrap)
    );

    // Decode of the next position; a frozen raster decodes to the same values.
    always_comb begin
        hsync_d_n     = (h_phase_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d_n     = (v_phase_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        blank_d_n     = (h_phase_nxt != PH_ACTIVE) || (v_phase_nxt != PH_ACTIVE);
        line_start_d  = restart || h_wrap;
        frame_start_d = restart || (h_wrap && v_wrap);
    end

    // Output registers; strobes are single-cycle because their causes are.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d_n;
            vsync_q       <= vsync_d_n;
            blank_q       <= blank_d_n;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    generate
        if (PIPE_DELAY == 0) begin : g_nopipe
            assign {hsync_d, vsync_d, blank_b_d} = {hsync_q, vsync_q, ~blank_q};
        end else begin : g_pipe
            localparam logic [2:0] PIPE_RST = {~H_SYNC_POL, ~V_SYNC_POL, 1'b1};
            logic [2:0] pipe_q [PIPE_DELAY];

            // Delay line shifts only when the raster moves, so it stays in step across freezes.
            always_ff @(posedge pixel_clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= PIPE_RST;
                end else if (enable || restart) begin
                    pipe_q[0] <= {hsync_q, vsync_q, ~blank_q};
                    for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign {hsync_d, vsync_d, blank_b_d} = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

endmodule
